// File: rtl/tree_reduce_scheduler.sv
// tree_reduce_scheduler: sequences a configurable binary tree adder over
// multi-beat reduction jobs and accumulates the per-beat sums into one result.
//
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   cfg_valid_i/cfg_ready_o             job descriptor handshake
//   cfg_len_i, cfg_halved_i             beat count (0 allowed), precision mode
//   in_valid_i/in_ready_o, in_data_i    operand beat stream (INPUTS_AMOUNT x P)
//   out_valid_o/out_ready_i             result handshake
//   out_sum_o, out_ovf_o                accumulated sum, sticky wrap flag
//   busy_o                              a job is in progress (state != IDLE)
module tree_reduce_scheduler #(
    parameter int P             = 16,
    parameter int INPUTS_AMOUNT = 8,
    parameter int ACC_W         = 32,
    parameter int LEN_W         = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [LEN_W-1:0]             cfg_len_i,
    input  logic                         cfg_halved_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [INPUTS_AMOUNT*P-1:0]   in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ACC_W-1:0]             out_sum_o,
    output logic                         out_ovf_o,
    output logic                         busy_o
);

    localparam int TW = 2 * P;
    localparam int H  = P / 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0]        count;
    logic                    halved;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;

    logic                    cfg_fire;
    logic                    in_fire;
    logic                    out_fire;

    logic signed [TW-1:0]    tree_out;
    logic signed [ACC_W-1:0] beat_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    add_ovf;

    // Heap-ordered adder tree: leaves at [N .. 2N-1], root at [1].
    // In halved mode each leaf is the sum of the word's two signed lanes.
    function automatic logic signed [TW-1:0] tree_sum(
        input logic [INPUTS_AMOUNT*P-1:0] d,
        input logic                       h
    );
        logic signed [TW-1:0] n [2*INPUTS_AMOUNT];
        logic signed [P-1:0]  w;
        logic signed [H-1:0]  lo;
        logic signed [H-1:0]  hi;
        for (int i = 0; i < 2 * INPUTS_AMOUNT; i++) begin
            n[i] = '0;
        end
        for (int i = 0; i < INPUTS_AMOUNT; i++) begin
            w  = d[i*P +: P];
            lo = w[H-1:0];
            hi = w[P-1:H];
            if (h) begin
                n[INPUTS_AMOUNT+i] = TW'(lo) + TW'(hi);
            end else begin
                n[INPUTS_AMOUNT+i] = TW'(w);
            end
        end
        for (int i = INPUTS_AMOUNT - 1; i >= 1; i--) begin
            n[i] = n[2*i] + n[2*i+1];
        end
        return n[1];
    endfunction

    assign tree_out = tree_sum(in_data_i, halved);
    assign beat_ext = ACC_W'(tree_out);
    assign acc_sum  = acc + beat_ext;
    // Signed overflow: operands share a sign that the wrapped result lost.
    assign add_ovf  = (acc[ACC_W-1] == beat_ext[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc[ACC_W-1]);

    assign cfg_fire = cfg_valid_i && cfg_ready_o;
    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cfg_fire) begin
                    if (cfg_len_i == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_fire && (count == LEN_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend on the registered state only.
    always_comb begin
        cfg_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        unique case (state)
            IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            ACCUM: in_ready_o  = 1'b1;
            DONE:  out_valid_o = 1'b1;
            default: begin
                cfg_ready_o = 1'b0;
            end
        endcase
    end

    // Job datapath: descriptor latch, beat counter and accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            halved <= 1'b0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else if (cfg_fire) begin
            count  <= cfg_len_i;
            halved <= cfg_halved_i;
            acc    <= '0;
            ovf    <= 1'b0;
        end else if (in_fire) begin
            count  <= count - LEN_W'(1);
            acc    <= acc_sum;
            ovf    <= ovf | add_ovf;
        end
    end

    assign out_sum_o = acc;
    assign out_ovf_o = ovf;

endmodule

// File: tb/tb_tree_reduce_scheduler.sv
// tb_tree_reduce_scheduler: directed and random jobs with a result scoreboard.
// Expected results are queued at job issue and popped by an output monitor.
module tb_tree_reduce_scheduler;

    localparam int P     = 16;
    localparam int N     = 8;
    localparam int ACC_W = 32;
    localparam int LEN_W = 16;

    logic             clk;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_halved;
    logic             in_valid;
    logic             in_ready;
    logic [N*P-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_sum_q [$];
    logic        exp_ovf_q [$];

    tree_reduce_scheduler #(
        .P(P), .INPUTS_AMOUNT(N), .ACC_W(ACC_W), .LEN_W(LEN_W)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_len_i(cfg_len),
        .cfg_halved_i(cfg_halved),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_data_i(in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o(out_sum),
        .out_ovf_o(out_ovf),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_sum_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none",
                         out_sum);
            end else begin
                chk("result_sum", 64'(out_sum), 64'(exp_sum_q.pop_front()));
                chk("result_ovf", 64'(out_ovf), 64'(exp_ovf_q.pop_front()));
            end
        end
    end

    function automatic logic [127:0] mk(input int a, input int b,
        input int c, input int d, input int e, input int f,
        input int g, input int h);
        logic [127:0] r;
        r[0*16 +: 16] = a[15:0];
        r[1*16 +: 16] = b[15:0];
        r[2*16 +: 16] = c[15:0];
        r[3*16 +: 16] = d[15:0];
        r[4*16 +: 16] = e[15:0];
        r[5*16 +: 16] = f[15:0];
        r[6*16 +: 16] = g[15:0];
        r[7*16 +: 16] = h[15:0];
        return r;
    endfunction

    // Halved-mode beat with lanes s*1, s*2, ... s*16 (lane k at bits k*8).
    function automatic logic [127:0] mkh(input int s);
        logic [127:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            v = s * (k + 1);
            r[k*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic longint beat_model(input logic [127:0] d,
                                          input bit h);
        longint s;
        logic signed [15:0] w;
        logic signed [7:0]  l;
        s = 0;
        if (h) begin
            for (int k = 0; k < 16; k++) begin
                l = d[k*8 +: 8];
                s += longint'(l);
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                w = d[k*16 +: 16];
                s += longint'(w);
            end
        end
        return s;
    endfunction

    task automatic send_cfg(input int len, input bit h);
        int n;
        n = 0;
        cfg_len    = len[15:0];
        cfg_halved = h;
        cfg_valid  = 1'b1;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) fail_now("cfg_timeout");
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
        cfg_halved = ~h;
    endtask

    task automatic send_beat(input logic [127:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("beat_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_job(input int len, input bit h,
                          input logic [127:0] beats [$],
                          input logic [31:0] es, input bit eo,
                          input bit gap, input bit bp);
        exp_sum_q.push_back(es);
        exp_ovf_q.push_back(eo);
        send_cfg(len, h);
        if (len == 0) begin
            chk("len0_valid", 64'(out_valid), 64'(1));
            chk("len0_in_ready", 64'(in_ready), 64'(0));
        end else begin
            for (int i = 0; i < len; i++) begin
                send_beat(beats[i]);
                if (gap && i < len - 1) begin
                    repeat (2) @(posedge clk);
                    #1;
                end
            end
            chk("latency_valid", 64'(out_valid), 64'(1));
        end
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("bp_sum", 64'(out_sum), 64'(es));
                chk("bp_cfg_ready", 64'(cfg_ready), 64'(0));
                chk("bp_valid", 64'(out_valid), 64'(1));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        wait_idle();
    endtask

    initial begin
        logic [127:0] bq [$];
        logic [127:0] d;
        longint acc;
        longint s;
        bit ov;
        bit h;
        int len;

        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_len    = '0;
        cfg_halved = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Beats offered in IDLE are not consumed.
        in_valid = 1'b1;
        in_data  = mk(9, 9, 9, 9, 9, 9, 9, 9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // 1: single full-precision beat
        bq = {mk(1, 2, 3, 4, 5, 6, 7, 8)};
        do_job(1, 1'b0, bq, 32'd36, 1'b0, 1'b0, 1'b0);

        // 2: three full-precision beats
        bq = {mk(1, 2, 3, 4, 5, 6, 7, 8),
              mk(1, -2, 3, -4, 5, -6, 7, -8),
              mk(127, -128, 0, 1, 0, 0, 0, 0)};
        do_job(3, 1'b0, bq, 32'd32, 1'b0, 1'b0, 1'b0);

        // 3: halved precision
        bq = {mkh(1), mkh(-1)};
        do_job(2, 1'b1, bq, 32'd0, 1'b0, 1'b0, 1'b0);
        bq = {mkh(1)};
        do_job(1, 1'b1, bq, 32'd136, 1'b0, 1'b0, 1'b0);

        // 4: empty job
        bq = {};
        do_job(0, 1'b0, bq, 32'd0, 1'b0, 1'b0, 1'b0);

        // 5: result backpressure plus in_valid gaps
        bq = {mk(1, 2, 3, 4, 5, 6, 7, 8),
              mk(-100, 0, 0, 0, 0, 0, 0, 0),
              mk(10, 10, 10, 10, 10, 10, 10, 10)};
        out_ready = 1'b0;
        do_job(3, 1'b0, bq, 32'd16, 1'b0, 1'b1, 1'b1);

        // Negative result in full mode
        bq = {mk(-32768, -32768, -32768, -32768, 0, 0, 0, 0)};
        do_job(1, 1'b0, bq, 32'hFFFE_0000, 1'b0, 1'b0, 1'b0);

        // 6: random jobs against the model
        for (int j = 0; j < 30; j++) begin
            len = $urandom_range(1, 20);
            h   = 1'($urandom_range(0, 1));
            bq  = {};
            acc = 0;
            ov  = 1'b0;
            for (int i = 0; i < len; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                bq.push_back(d);
                s = acc + beat_model(d, h);
                if (s > 64'sd2147483647 || s < -64'sd2147483648) ov = 1'b1;
                acc = longint'($signed(s[31:0]));
            end
            do_job(len, h, bq, acc[31:0], ov, 1'($urandom_range(0, 1)),
                   1'b0);
        end

        // Reset mid-job aborts with no result.
        send_cfg(5, 1'b0);
        send_beat(mk(1, 1, 1, 1, 1, 1, 1, 1));
        send_beat(mk(2, 2, 2, 2, 2, 2, 2, 2));
        rst_n = 1'b0;
        #2;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_valid", 64'(out_valid), 64'(0));
        chk("abort_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("abort_in_ready", 64'(in_ready), 64'(0));
        chk("abort_sum", 64'(out_sum), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        bq = {mk(5, 5, 5, 5, 5, 5, 5, 5)};
        do_job(1, 1'b0, bq, 32'd40, 1'b0, 1'b0, 1'b0);

        // Accumulator wrap: 8193 beats of 8*32767 exceed 2^31-1.
        bq = {};
        for (int i = 0; i < 8193; i++) begin
            bq.push_back(mk(32767, 32767, 32767, 32767,
                            32767, 32767, 32767, 32767));
        end
        do_job(8193, 1'b0, bq, 32'h8002_FFF8, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_sum_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
